// File: rtl/led_pwm_decoder.sv
// led_pwm_decoder: recovers the duty value (high-cycle count) of an LED PWM
// waveform framed by a sync marker. Both inputs are synchronized with equal
// delay, each frame is measured sample by sample, and the result is held
// under a valid/ready handshake with sticky overrun reporting.
module led_pwm_decoder #(
   parameter int WIDTH  = 12,
   parameter int PERIOD = 4095
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             pwm_in,
   input  logic             sync_in,
   input  logic             duty_ready,
   input  logic             clr_err,
   output logic [WIDTH-1:0] duty,
   output logic             duty_valid,
   output logic             frame_err,
   output logic             sync_err,
   output logic             overrun
);

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] LAST_POS  = WIDTH'(PERIOD - 1);
   localparam logic [WIDTH-1:0] PERIOD_W  = WIDTH'(PERIOD);

   // Synchronizers, sync edge detector and previous pwm sample
   logic pwm_meta_q, pwm_s_q, pwm_prev_q;
   logic sync_meta_q, sync_s_q, sync_prev_q;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pos_cnt_q, pos_cnt_d;
   logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
   logic             seen_fall_q, seen_fall_d;
   logic             shape_bad_q, shape_bad_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             duty_valid_q, duty_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             sync_err_q, sync_err_d;
   logic             overrun_q, overrun_d;

   logic             frame_start;
   logic             pwm_rise, pwm_fall;
   logic [WIDTH-1:0] high_next;
   logic             new_result;
   logic             overrun_set;

   // Two-flop synchronizers with identical depth keep pwm and sync aligned
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         pwm_meta_q  <= 1'b0;
         pwm_s_q     <= 1'b0;
         pwm_prev_q  <= 1'b0;
         sync_meta_q <= 1'b0;
         sync_s_q    <= 1'b0;
         sync_prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the old value,
         // which is what makes a chain of registers a shift register.
         pwm_meta_q  <= pwm_in;
         pwm_s_q     <= pwm_meta_q;
         pwm_prev_q  <= pwm_s_q;
         sync_meta_q <= sync_in;
         sync_s_q    <= sync_meta_q;
         sync_prev_q <= sync_s_q;
      end
   end

   // State, counters and result registers
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         pos_cnt_q    <= '0;
         high_cnt_q   <= '0;
         seen_fall_q  <= 1'b0;
         shape_bad_q  <= 1'b0;
         duty_q       <= '0;
         duty_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         sync_err_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_cnt_q    <= pos_cnt_d;
         high_cnt_q   <= high_cnt_d;
         seen_fall_q  <= seen_fall_d;
         shape_bad_q  <= shape_bad_d;
         duty_q       <= duty_d;
         duty_valid_q <= duty_valid_d;
         frame_err_q  <= frame_err_d;
         sync_err_q   <= sync_err_d;
         overrun_q    <= overrun_d;
      end
   end

   // Frame measurement FSM, result capture and handshake
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      pos_cnt_d    = pos_cnt_q;
      high_cnt_d   = high_cnt_q;
      seen_fall_d  = seen_fall_q;
      shape_bad_d  = shape_bad_q;
      duty_d       = duty_q;
      duty_valid_d = duty_valid_q;
      frame_err_d  = frame_err_q;
      sync_err_d   = 1'b0;
      new_result   = 1'b0;
      overrun_set  = 1'b0;

      frame_start = sync_s_q & ~sync_prev_q;
      pwm_rise    = pwm_s_q & ~pwm_prev_q;
      pwm_fall    = ~pwm_s_q & pwm_prev_q;
      // Saturating accumulate: never exceeds PERIOD
      high_next   = (pwm_s_q && (high_cnt_q < PERIOD_W)) ? high_cnt_q + 1'b1 : high_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d     = MEAS;
               pos_cnt_d   = WIDTH'(1);
               high_cnt_d  = WIDTH'(pwm_s_q);
               seen_fall_d = 1'b0;
               shape_bad_d = 1'b0;
            end
         end
         MEAS: begin
            if (frame_start) begin
               // Early frame start: drop the partial frame and restart here
               sync_err_d  = 1'b1;
               pos_cnt_d   = WIDTH'(1);
               high_cnt_d  = WIDTH'(pwm_s_q);
               seen_fall_d = 1'b0;
               shape_bad_d = 1'b0;
            end else if (pos_cnt_q == LAST_POS) begin
               new_result  = 1'b1;
               state_d     = IDLE;
               pos_cnt_d   = '0;
               high_cnt_d  = '0;
               seen_fall_d = 1'b0;
               shape_bad_d = 1'b0;
            end else begin
               pos_cnt_d   = pos_cnt_q + 1'b1;
               high_cnt_d  = high_next;
               seen_fall_d = seen_fall_q | pwm_fall;
               shape_bad_d = shape_bad_q | (pwm_rise & seen_fall_q);
            end
         end
         default: state_d = IDLE;
      endcase

      if (new_result) begin
         duty_d       = high_next;
         frame_err_d  = shape_bad_q | (pwm_rise & seen_fall_q);
         duty_valid_d = 1'b1;
         overrun_set  = duty_valid_q & ~duty_ready;
      end else if (duty_ready) begin
         duty_valid_d = 1'b0;
      end

      // Set has priority over clear
      overrun_d = overrun_set | (overrun_q & ~clr_err);
   end

   assign duty       = duty_q;
   assign duty_valid = duty_valid_q;
   assign frame_err  = frame_err_q;
   assign sync_err   = sync_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_led_pwm_decoder.sv
// Directed testbench for led_pwm_decoder with default parameters
// (WIDTH=12, PERIOD=4095). Inputs change 2 ns after a rising edge and
// outputs are checked away from the edge.
module tb_led_pwm_decoder;

   localparam int WIDTH  = 12;
   localparam int PERIOD = 4095;

   logic             clk = 1'b0;
   logic             RST;
   logic             pwm_in;
   logic             sync_in;
   logic             duty_ready;
   logic             clr_err;
   logic [WIDTH-1:0] duty;
   logic             duty_valid;
   logic             frame_err;
   logic             sync_err;
   logic             overrun;

   int n_vec = 0;
   int n_err = 0;

   // Monitor counters
   int               hs_cnt   = 0;
   int               vld_cnt  = 0;
   int               serr_cnt = 0;
   logic [WIDTH-1:0] hs_duty  = '0;
   logic             hs_ferr  = 1'b0;

   int hs_base, vld_base, serr_base;

   always #5 clk = ~clk;

   led_pwm_decoder #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
      .clk        (clk),
      .RST        (RST),
      .pwm_in     (pwm_in),
      .sync_in    (sync_in),
      .duty_ready (duty_ready),
      .clr_err    (clr_err),
      .duty       (duty),
      .duty_valid (duty_valid),
      .frame_err  (frame_err),
      .sync_err   (sync_err),
      .overrun    (overrun)
   );

   // Record handshakes, valid cycles and sync_err pulses
   always @(negedge clk) begin
      if (duty_valid) vld_cnt++;
      if (duty_valid && duty_ready) begin
         hs_cnt++;
         hs_duty = duty;
         hs_ferr = frame_err;
      end
      if (sync_err) serr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic pat(input int p, input int lead, input int h1,
                                input int gap, input int h2);
      return ((p >= lead) && (p < lead + h1)) ||
             ((p >= lead + h1 + gap) && (p < lead + h1 + gap + h2));
   endfunction

   // Drive frame positions 0..len-1; sync high for the first sync_len positions
   task automatic drive_frame(input int lead, input int h1, input int gap, input int h2,
                              input int len, input int sync_len);
      for (int p = 0; p < len; p++) begin
         @(posedge clk);
         #2;
         pwm_in  = pat(p, lead, h1, gap, h2);
         sync_in = (p < sync_len);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         pwm_in  = 1'b0;
         sync_in = 1'b0;
      end
   endtask

   initial begin
      RST        = 1'b0;
      pwm_in     = 1'b0;
      sync_in    = 1'b0;
      duty_ready = 1'b1;
      clr_err    = 1'b0;
      idle(3);

      // Reset state
      check("rst_duty", 32'(duty), 0);
      check("rst_valid", 32'(duty_valid), 0);
      check("rst_ferr", 32'(frame_err), 0);
      check("rst_serr", 32'(sync_err), 0);
      check("rst_ovr", 32'(overrun), 0);

      RST = 1'b1;
      // pwm activity without any sync must not produce a result
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #2;
         pwm_in = 1'b1;
      end
      idle(5);
      check("no_sync_no_valid", 32'(hs_cnt), 0);

      // Two back-to-back 2048/4095 frames, second with a 3-cycle sync pulse
      hs_base = hs_cnt; vld_base = vld_cnt; serr_base = serr_cnt;
      drive_frame(1000, 2048, 0, 0, PERIOD, 1);
      drive_frame(0, 2048, 0, 0, PERIOD, 3);
      idle(6);
      check("pwm2048_hs", 32'(hs_cnt - hs_base), 2);
      check("pwm2048_vcycles", 32'(vld_cnt - vld_base), 2);
      check("pwm2048_duty", 32'(hs_duty), 2048);
      check("pwm2048_ferr", 32'(hs_ferr), 0);
      check("pwm2048_no_serr", 32'(serr_cnt - serr_base), 0);

      // All-low frame with exact 3-cycle latency and 1-cycle valid
      drive_frame(0, 0, 0, 0, PERIOD, 1);
      idle(1);
      idle(1);
      check("lat_valid_early", 32'(duty_valid), 0);
      idle(1);
      check("lat_valid_on", 32'(duty_valid), 1);
      check("low_duty", 32'(duty), 0);
      idle(3);
      check("low_valid_pulse", 32'(duty_valid), 0);

      // All-high frame
      drive_frame(0, PERIOD, 0, 0, PERIOD, 1);
      idle(6);
      check("high_duty", 32'(hs_duty), PERIOD);
      check("high_ferr", 32'(hs_ferr), 0);

      // Early sync at position 100 aborts the frame; restarted frame reports 700
      hs_base = hs_cnt; serr_base = serr_cnt;
      drive_frame(0, 50, 0, 0, 100, 1);
      drive_frame(0, 700, 0, 0, PERIOD, 1);
      idle(6);
      check("abort_serr", 32'(serr_cnt - serr_base), 1);
      check("abort_hs", 32'(hs_cnt - hs_base), 1);
      check("abort_duty", 32'(hs_duty), 700);

      // Held result and overrun
      duty_ready = 1'b0;
      drive_frame(500, 1000, 0, 0, PERIOD, 1);
      idle(6);
      check("hold_duty", 32'(duty), 1000);
      check("hold_valid", 32'(duty_valid), 1);
      check("hold_ovr", 32'(overrun), 0);
      check("hold_ferr", 32'(frame_err), 0);
      drive_frame(0, 3000, 0, 0, PERIOD, 1);
      idle(6);
      check("ovr_duty", 32'(duty), 3000);
      check("ovr_valid", 32'(duty_valid), 1);
      check("ovr_set", 32'(overrun), 1);
      @(posedge clk); #2; clr_err = 1'b1;
      @(posedge clk); #2; clr_err = 1'b0;
      check("ovr_clr", 32'(overrun), 0);
      check("ovr_clr_valid", 32'(duty_valid), 1);

      // New result lands in the same cycle duty_ready is high: no overrun
      drive_frame(0, 1500, 0, 0, PERIOD, 1);
      idle(1);
      @(posedge clk); #2; pwm_in = 1'b0; duty_ready = 1'b1;
      @(posedge clk); #2; duty_ready = 1'b0;
      check("land_ready_duty", 32'(duty), 1500);
      check("land_ready_valid", 32'(duty_valid), 1);
      check("land_ready_ovr", 32'(overrun), 0);
      @(posedge clk); #2; duty_ready = 1'b1;
      @(posedge clk); #2;
      check("consume_valid", 32'(duty_valid), 0);

      // Two high pulses in one frame
      drive_frame(0, 10, 5, 10, PERIOD, 1);
      idle(6);
      check("shape_duty", 32'(hs_duty), 20);
      check("shape_ferr", 32'(hs_ferr), 1);

      // Reset in the middle of a frame
      hs_base = hs_cnt;
      drive_frame(0, 3000, 0, 0, 2000, 1);
      @(posedge clk); #2; pwm_in = 1'b1;
      RST = 1'b0;
      #1;
      check("midrst_duty", 32'(duty), 0);
      check("midrst_valid", 32'(duty_valid), 0);
      check("midrst_ferr", 32'(frame_err), 0);
      check("midrst_serr", 32'(sync_err), 0);
      check("midrst_ovr", 32'(overrun), 0);
      @(posedge clk); #2;
      @(posedge clk); #2; RST = 1'b1;
      for (int p = 2003; p < PERIOD; p++) begin
         @(posedge clk); #2;
         pwm_in = (p < 3000);
      end
      idle(6);
      check("midrst_no_hs", 32'(hs_cnt - hs_base), 0);
      check("midrst_no_valid", 32'(duty_valid), 0);
      drive_frame(200, 1234, 0, 0, PERIOD, 1);
      idle(6);
      check("post_rst_hs", 32'(hs_cnt - hs_base), 1);
      check("post_rst_duty", 32'(hs_duty), 1234);
      check("post_rst_ferr", 32'(hs_ferr), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/led_pwm_decoder.md
LED_PWM_DECODER -- requirements
Module: led_pwm_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 12, the recovered duty-value width.
REQ-002 SHALL have parameter PERIOD, default 4095, the PWM frame length in clk cycles; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  sampling clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pwm_in  input  1  LED power waveform; asynchronous to clk.
REQ-006 SHALL have port sync_in  input  1  frame-start marker, high for one or more cycles at frame position 0; asynchronous to clk.
REQ-007 SHALL have port duty_ready  input  1  consumer accepts duty when high with duty_valid.
REQ-008 SHALL have port clr_err  input  1  synchronous clear of the sticky overrun flag.
REQ-009 SHALL have port duty  output  WIDTH  recovered high-cycle count of the last completed frame.
REQ-010 SHALL have port duty_valid  output  1  duty holds an unconsumed result.
REQ-011 SHALL have port frame_err  output  1  the held result came from a frame with more than one high pulse.
REQ-012 SHALL have port sync_err  output  1  one-cycle pulse on an early frame start.
REQ-013 SHALL have port overrun  output  1  sticky flag: an unconsumed result was overwritten.

Function
REQ-014 SHALL pass pwm_in and sync_in through identical 2-flop synchronizers (pwm_s, sync_s) so that both signals keep the same alignment.
REQ-015 SHALL define a frame-start event F as the rising edge of sync_s; a multi-cycle sync pulse SHALL yield exactly one F.
REQ-016 SHALL implement states IDLE and MEAS; reset state IDLE.
REQ-017 In IDLE, F SHALL move to MEAS with pos_cnt<=1, high_cnt<=pwm_s (the F cycle is sample 0); other cycles hold.
REQ-018 In MEAS, each cycle SHALL increment pos_cnt, add pwm_s to high_cnt, and track shape: a 0->1 transition of pwm_s after a 1->0 transition within the frame sets shape_bad.
REQ-019 In MEAS, F at any pos_cnt in 1..PERIOD-1 SHALL pulse sync_err for one cycle, discard the frame without a result, and restart as in REQ-017 (state stays MEAS).
REQ-020 In MEAS, the cycle with pos_cnt==PERIOD-1 and no F SHALL be the last sample: the next cycle duty=high_cnt+pwm_s, frame_err=shape_bad (including this cycle), duty_valid=1, state IDLE.
REQ-021 high_cnt SHALL saturate at no value below PERIOD; a frame that is high for all cycles SHALL report duty=PERIOD; an all-low frame SHALL report 0 with duty_valid=1.
REQ-022 duty_valid SHALL stay high and duty/frame_err SHALL stay stable until a cycle with duty_ready=1 clears duty_valid.
REQ-023 If a new result lands while duty_valid=1 and duty_ready=0, it SHALL overwrite duty/frame_err and set overrun; if duty_ready=1 in that cycle, there SHALL be no overrun and duty_valid SHALL stay 1 with the new data.
REQ-024 overrun SHALL clear only on clr_err=1 or reset; if set and clear occur in the same cycle, set SHALL win.
REQ-025 Latency SHALL be 3 clk from the pwm_in/sync_in edge of the last frame sample to duty_valid (2 synchronizer cycles + 1 capture).
REQ-026 Arithmetic: pos_cnt and high_cnt SHALL be WIDTH bits with no wrap inside a frame, since PERIOD<=2^WIDTH-1.

Reset
REQ-027 RST low SHALL immediately force: duty=0, duty_valid=0, frame_err=0, sync_err=0, overrun=0, synchronizers=0, counters=0, state IDLE.
REQ-028 After RST deasserts, the block SHALL report nothing until the first F; a reset in the middle of a frame SHALL discard that frame.

Verification
REQ-029 PWM with 2048 high cycles per 4095-cycle frame, sync each frame, duty_ready=1 -> duty=2048 and a 1-cycle duty_valid per frame; frame_err=0.
REQ-030 All-low frame -> duty=0, valid; all-high frame -> duty=4095, valid.
REQ-031 F at frame position 100 -> sync_err pulse, no valid for the aborted frame; the next full frame reports the correct duty.
REQ-032 duty_ready=0 across two frames (1000 then 3000) -> duty=1000 held, then overwritten by 3000 with overrun=1; clr_err pulse -> overrun=0.
REQ-033 Frame pattern high 10, low 5, high 10, then low -> duty=20, frame_err=1.
REQ-034 RST low at frame position 2000 -> all outputs 0 in the same cycle; after release, no valid until the next sync, then a correct result.
